// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding for the bit-serial adder controller
package serial_add_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_add_seq_fa.sv
// full_adder: single-bit combinational full adder
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_seq.sv
// serial_add_seq: WIDTH-cycle bit-serial adder built around one shared full_adder
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr;
  logic [CW-1:0]    cnt;
  logic             carry, fa_s, fa_c, last;
  full_adder u_fa (.a(a_sr[0]), .b(b_sr[0]), .cin(carry), .sum(fa_s), .cout(fa_c));
  assign busy = state == ST_RUN;
  assign done = state == ST_DONE;
  assign last = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (state == ST_RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      r_sr  <= {fa_s, r_sr[WIDTH-1:1]};
      carry <= fa_c;
      cnt   <= cnt + 1'b1;
      if (last) begin
        sum   <= {fa_s, r_sr[WIDTH-1:1]};
        cout  <= fa_c;
        state <= ST_DONE;
      end
    end else if (start) begin
      a_sr  <= a;
      b_sr  <= b;
      carry <= cin;
      cnt   <= '0;
      state <= ST_RUN;
    end else begin
      state <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_serial_add_seq.sv
// tb_serial_add_seq: directed checks of the 8-bit adder plus an exhaustive 4-bit sweep
module tb_serial_add_seq;
  logic       clk = 1'b0, rst = 1'b1;
  logic       start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       start4 = 1'b0, cin4 = 1'b0, busy4, done4, cout4;
  logic [3:0] a4 = '0, b4 = '0, sum4;
  int         n_vec = 0, n_err = 0, n_done4 = 0, n_ovl = 0;

  always #5 clk = ~clk;

  serial_add_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );
  serial_add_seq #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  always @(negedge clk) begin
    if (done4) n_done4++;
    if ((busy8 && done8) || (busy4 && done4)) n_ovl++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic c);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
  endtask

  // Call with start8 raised at a negedge; returns at the negedge of the done cycle.
  task automatic wait8(input string tag, input logic [7:0] es, input logic ec, input int poke);
    int   cyc = 1, nbusy = 0, moved = 0;
    logic [7:0] s0 = sum8;
    logic c0 = cout8;
    @(negedge clk);
    start8 = 1'b0;
    while (!done8 && cyc < 40) begin
      if (busy8) nbusy++;
      if (sum8 !== s0 || cout8 !== c0) moved++;
      if (cyc == poke) begin start8 = 1'b1; a8 = ~a8; b8 = 8'hFF; cin8 = ~cin8; end
      if (cyc == poke + 1) start8 = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'd9);
    check({tag, "_busy_cycles"}, 32'(nbusy), 32'd8);
    check({tag, "_held"}, 32'(moved), 32'd0);
    check({tag, "_sum"}, {24'd0, sum8}, {24'd0, es});
    check({tag, "_cout"}, {31'd0, cout8}, {31'd0, ec});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ex, cyc, nd;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy8}, 32'd0);
    check("rst_done", {31'd0, done8}, 32'd0);
    check("rst_sum", {24'd0, sum8}, 32'd0);
    check("rst_cout", {31'd0, cout8}, 32'd0);
    rst = 1'b0;
    @(negedge clk); launch8(8'h00, 8'h00, 1'b0); wait8("zero", 8'h00, 1'b0, 0);
    @(negedge clk);
    check("done_pulse", {31'd0, done8}, 32'd0);
    launch8(8'hFF, 8'h01, 1'b0); wait8("ff01", 8'h00, 1'b1, 0);
    @(negedge clk); launch8(8'hA5, 8'h5A, 1'b1); wait8("a55a", 8'h00, 1'b1, 0);
    @(negedge clk); launch8(8'h3C, 8'h0F, 1'b1); wait8("ignore", 8'h4C, 1'b0, 3);
    launch8(8'h01, 8'h01, 1'b0); wait8("b2b", 8'h02, 1'b0, 0);
    @(negedge clk); launch8(8'hFF, 8'h01, 1'b0);
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", {31'd0, busy8}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy8}, 32'd0);
    check("arst_done", {31'd0, done8}, 32'd0);
    check("arst_sum", {24'd0, sum8}, 32'd0);
    check("arst_cout", {31'd0, cout8}, 32'd0);
    @(negedge clk); rst = 1'b0;
    nd = 0;
    repeat (12) begin @(negedge clk); if (done8 || busy8) nd++; end
    check("arst_quiet", 32'(nd), 32'd0);
    launch8(8'h80, 8'h80, 1'b1); wait8("post_rst", 8'h01, 1'b1, 0);
    n_done4 = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      a4 = 4'(i); b4 = 4'(i >> 4); cin4 = 1'(i >> 8); start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      cyc = 1;
      while (!done4 && cyc < 20) begin @(negedge clk); cyc++; end
      ex = (i & 15) + ((i >> 4) & 15) + (i >> 8);
      check($sformatf("w4_%0d", i), {22'd0, 5'(cyc), cout4, sum4}, {22'd0, 5'd5, 5'(ex)});
    end
    @(negedge clk);
    check("w4_done_count", 32'(n_done4), 32'd512);
    check("no_overlap", 32'(n_ovl), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
